// File: rtl/pe_unit_affine.sv
// -----------------------------------------------------------------------------
// pe_unit_affine
// Smith-Waterman processing element with affine gap scoring (Gotoh H/E/F).
// Each valid beat computes one local-alignment cell, registers it with a
// one-cycle latency, and keeps a running best score plus its column index.
// One instance per array column, daisy-chained to its neighbours.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   start                 synchronous clear of column counter and best tracking
//   in_valid              cell inputs valid this cycle
//   ref_base, qry_base    reference base and the query base held by this PE
//   h_diag, h_up, h_left  H scores of the diagonal, upper and left neighbours
//   e_left, f_up          E of the left neighbour, F of the upper neighbour
//   pos_diag/up/left      origin tags of the three sources
//   out_valid             outputs updated this cycle
//   h_out, e_out, f_out   cell H/E/F
//   h_prev                previous h_out (diagonal feed for the next PE)
//   out_pos, out_dir      origin tag and traceback code of the winning source
//   best_score, best_col  max h_out since last start and its column
// -----------------------------------------------------------------------------
module pe_unit_affine #(
    parameter int SCORE_W  = 8,
    parameter int BASE_W   = 3,
    parameter int POS_W    = 3,
    parameter int COL_W    = 10,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP_OPEN = 2,
    parameter int GAP_EXT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BASE_W-1:0]  ref_base,
    input  logic [BASE_W-1:0]  qry_base,
    input  logic [SCORE_W-1:0] h_diag,
    input  logic [SCORE_W-1:0] h_up,
    input  logic [SCORE_W-1:0] h_left,
    input  logic [SCORE_W-1:0] e_left,
    input  logic [SCORE_W-1:0] f_up,
    input  logic [POS_W-1:0]   pos_diag,
    input  logic [POS_W-1:0]   pos_up,
    input  logic [POS_W-1:0]   pos_left,
    output logic               out_valid,
    output logic [SCORE_W-1:0] h_out,
    output logic [SCORE_W-1:0] h_prev,
    output logic [SCORE_W-1:0] e_out,
    output logic [SCORE_W-1:0] f_out,
    output logic [POS_W-1:0]   out_pos,
    output logic [1:0]         out_dir,
    output logic [SCORE_W-1:0] best_score,
    output logic [COL_W-1:0]   best_col
);

    // Two guard bits: one for the carry of a sum, one for the sign of a
    // difference, so neither can wrap before it is clamped.
    localparam int IW = SCORE_W + 2;
    typedef logic signed [IW-1:0] sint_t;

    typedef enum logic [1:0] {
        DIR_ZERO = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } dir_t;

    localparam sint_t SCORE_MAX = sint_t'((1 << SCORE_W) - 1);

    function automatic sint_t widen(input logic [SCORE_W-1:0] v);
        return sint_t'({2'b00, v});
    endfunction

    // Floor at 0 and clamp to the largest representable score.
    function automatic logic [SCORE_W-1:0] clamp(input sint_t v);
        if (v < 0)
            return '0;
        if (v > SCORE_MAX)
            return SCORE_MAX[SCORE_W-1:0];
        return v[SCORE_W-1:0];
    endfunction

    sint_t              subst;
    logic [SCORE_W-1:0] d_val, e_open, e_ext, e_val, f_open, f_ext, f_val, h_val;
    dir_t               dir_val;
    logic [POS_W-1:0]   pos_val;
    logic [COL_W-1:0]   col_cnt, col_idx;
    logic [SCORE_W-1:0] best_base;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        subst   = (ref_base == qry_base) ? sint_t'(MATCH) : -sint_t'(MISMATCH);
        d_val   = clamp(widen(h_diag) + subst);
        e_open  = clamp(widen(h_left) - sint_t'(GAP_OPEN));
        e_ext   = clamp(widen(e_left) - sint_t'(GAP_EXT));
        e_val   = (e_open >= e_ext) ? e_open : e_ext;
        f_open  = clamp(widen(h_up) - sint_t'(GAP_OPEN));
        f_ext   = clamp(widen(f_up) - sint_t'(GAP_EXT));
        f_val   = (f_open >= f_ext) ? f_open : f_ext;

        h_val   = '0;
        dir_val = DIR_ZERO;
        pos_val = '1;
        // Comparison order realises the tie priority diag > up > left.
        if (d_val >= f_val && d_val >= e_val) begin
            h_val   = d_val;
            dir_val = DIR_DIAG;
            pos_val = pos_diag;
        end else if (f_val >= e_val) begin
            h_val   = f_val;
            dir_val = DIR_UP;
            pos_val = pos_up;
        end else begin
            h_val   = e_val;
            dir_val = DIR_LEFT;
            pos_val = pos_left;
        end
        // A zero cell is a fresh local-alignment start, whatever source tied.
        if (h_val == '0) begin
            dir_val = DIR_ZERO;
            pos_val = '1;
        end
    end

    // start in the same cycle as a valid cell processes it as column 0 and
    // compares it against a cleared best.
    assign col_idx   = start ? '0 : col_cnt;
    assign best_base = start ? '0 : best_score;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            h_out      <= '0;
            h_prev     <= '0;
            e_out      <= '0;
            f_out      <= '0;
            out_pos    <= '1;
            out_dir    <= DIR_ZERO;
            best_score <= '0;
            best_col   <= '0;
            col_cnt    <= '0;
        end else begin
            out_valid <= in_valid;
            if (start) begin
                col_cnt    <= '0;
                best_score <= '0;
                best_col   <= '0;
            end
            if (in_valid) begin
                h_prev  <= h_out;
                h_out   <= h_val;
                e_out   <= e_val;
                f_out   <= f_val;
                out_dir <= dir_val;
                out_pos <= pos_val;
                col_cnt <= col_idx + COL_W'(1);
                // Strictly greater: ties keep the earliest column.
                if (h_val > best_base) begin
                    best_score <= h_val;
                    best_col   <= col_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_unit_affine.sv
// -----------------------------------------------------------------------------
// tb_pe_unit_affine
// Self-checking bench for pe_unit_affine. A reference model predicts the
// register snapshot after every clock edge; the snapshot is queued when the
// stimulus is driven and popped after the edge for comparison.
// -----------------------------------------------------------------------------
module tb_pe_unit_affine;

    localparam int SCORE_W  = 8;
    localparam int BASE_W   = 3;
    localparam int POS_W    = 3;
    localparam int COL_W    = 10;
    localparam int MATCH    = 2;
    localparam int MISMATCH = 1;
    localparam int GAP_OPEN = 2;
    localparam int GAP_EXT  = 1;
    localparam int SMAX     = (1 << SCORE_W) - 1;
    localparam int NO_POS   = (1 << POS_W) - 1;
    localparam int PD = 1, PU = 2, PL = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic [BASE_W-1:0]  ref_base, qry_base;
    logic [SCORE_W-1:0] h_diag, h_up, h_left, e_left, f_up;
    logic [POS_W-1:0]   pos_diag, pos_up, pos_left;
    logic               out_valid;
    logic [SCORE_W-1:0] h_out, h_prev, e_out, f_out, best_score;
    logic [POS_W-1:0]   out_pos;
    logic [1:0]         out_dir;
    logic [COL_W-1:0]   best_col;

    always #5 clk = ~clk;

    pe_unit_affine dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .ref_base(ref_base), .qry_base(qry_base),
        .h_diag(h_diag), .h_up(h_up), .h_left(h_left), .e_left(e_left), .f_up(f_up),
        .pos_diag(pos_diag), .pos_up(pos_up), .pos_left(pos_left),
        .out_valid(out_valid), .h_out(h_out), .h_prev(h_prev), .e_out(e_out),
        .f_out(f_out), .out_pos(out_pos), .out_dir(out_dir),
        .best_score(best_score), .best_col(best_col)
    );

    typedef struct {
        int valid, h, prev, e, f, dir, pos, best, bcol;
    } snap_t;

    snap_t sb_q[$];
    snap_t m;
    snap_t got;
    int    m_cnt;
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic int fl(input int v);
        return (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        m = '{valid: 0, h: 0, prev: 0, e: 0, f: 0, dir: 0, pos: NO_POS, best: 0, bcol: 0};
        m_cnt = 0;
    endfunction

    // Drive one cycle, queue the predicted snapshot, clock, pop it into got.
    task automatic drive(input int v, input int st, input int hd, input int hu,
                         input int hl, input int el, input int fu,
                         input int rb, input int qb);
        int d, e, f, h, dir, pos;
        in_valid = v[0];  start = st[0];
        h_diag = SCORE_W'(hd); h_up = SCORE_W'(hu); h_left = SCORE_W'(hl);
        e_left = SCORE_W'(el); f_up = SCORE_W'(fu);
        ref_base = BASE_W'(rb); qry_base = BASE_W'(qb);
        d = fl(hd + ((rb == qb) ? MATCH : -MISMATCH));
        e = mx(fl(hl - GAP_OPEN), fl(el - GAP_EXT));
        f = mx(fl(hu - GAP_OPEN), fl(fu - GAP_EXT));
        h = mx(mx(0, d), mx(f, e));
        if (h == 0)      begin dir = 0; pos = NO_POS; end
        else if (h == d) begin dir = 1; pos = PD; end
        else if (h == f) begin dir = 2; pos = PU; end
        else             begin dir = 3; pos = PL; end
        if (st != 0) begin m_cnt = 0; m.best = 0; m.bcol = 0; end
        if (v != 0) begin
            m.prev = m.h; m.h = h; m.e = e; m.f = f; m.dir = dir; m.pos = pos;
            if (h > m.best) begin m.best = h; m.bcol = m_cnt; end
            m_cnt = (m_cnt + 1) % (1 << COL_W);
        end
        m.valid = v;
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        ref_base = '0; qry_base = '0;
        h_diag = '0; h_up = '0; h_left = '0; e_left = '0; f_up = '0;
        pos_diag = POS_W'(PD); pos_up = POS_W'(PU); pos_left = POS_W'(PL);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, h_out, h_prev, e_out, f_out, out_dir, best_score, best_col} !== '0) begin
            n_err++;
            $display("FAIL reset_zero: valid=%0b h=%0d prev=%0d e=%0d f=%0d dir=%0d best=%0d col=%0d, all required 0",
                     out_valid, h_out, h_prev, e_out, f_out, out_dir, best_score, best_col);
        end
        n_cmp++;
        if (out_pos !== POS_W'(NO_POS)) begin
            n_err++;
            $display("FAIL reset_pos: got %0d want %0d", out_pos, NO_POS);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_match_diag();
        drive(1, 1, 5, 6, 4, 0, 3, 2, 2);
        n_cmp++;
        if (out_valid !== 1'b1 || h_out !== SCORE_W'(got.h) || h_out !== 8'd7) begin
            n_err++;
            $display("FAIL diag_h: valid=%0b h=%0d want valid=1 h=7 (model %0d)", out_valid, h_out, got.h);
        end
        n_cmp++;
        if (f_out !== 8'd4 || e_out !== 8'd2) begin
            n_err++;
            $display("FAIL diag_ef: e=%0d f=%0d want e=2 f=4", e_out, f_out);
        end
        n_cmp++;
        if (out_dir !== 2'b01 || out_pos !== POS_W'(PD)) begin
            n_err++;
            $display("FAIL diag_dir: dir=%0d pos=%0d want dir=1 pos=%0d", out_dir, out_pos, PD);
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 254, 0, 0, 0, 0, 5, 5);
        n_cmp++;
        if (h_out !== 8'd255 || out_dir !== 2'b01) begin
            n_err++;
            $display("FAIL sat_clamp: h=%0d dir=%0d want h=255 dir=1", h_out, out_dir);
        end
        drive(1, 0, 255, 0, 0, 0, 0, 1, 2);
        n_cmp++;
        if (h_out !== 8'd254 || h_prev !== 8'd255) begin
            n_err++;
            $display("FAIL sat_mismatch: h=%0d prev=%0d want h=254 prev=255", h_out, h_prev);
        end
    endtask

    task automatic test_zero_floor();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 2);
        n_cmp++;
        if ({h_out, e_out, f_out, out_dir} !== '0 || out_pos !== POS_W'(NO_POS)) begin
            n_err++;
            $display("FAIL zero_floor: h=%0d e=%0d f=%0d dir=%0d pos=%0d want 0/0/0/0/%0d",
                     h_out, e_out, f_out, out_dir, out_pos, NO_POS);
        end
    endtask

    task automatic test_gap_tie();
        drive(1, 0, 0, 10, 0, 0, 9, 1, 2);
        n_cmp++;
        if (f_out !== 8'd8 || h_out !== 8'd8 || out_dir !== 2'b10 || out_pos !== POS_W'(PU)) begin
            n_err++;
            $display("FAIL gap_tie: f=%0d h=%0d dir=%0d pos=%0d want f=8 h=8 dir=2 pos=%0d",
                     f_out, h_out, out_dir, out_pos, PU);
        end
    endtask

    task automatic test_best_stall();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 3, 3);   // H=3, column 0
        drive(1, 0, 7, 0, 0, 0, 0, 3, 3);   // H=9, column 1
        drive(0, 0, 7, 0, 0, 0, 0, 3, 3);   // stall
        n_cmp++;
        if (out_valid !== 1'b0 || h_out !== 8'd9) begin
            n_err++;
            $display("FAIL stall_hold: valid=%0b h=%0d want valid=0 h=9", out_valid, h_out);
        end
        drive(1, 0, 7, 0, 0, 0, 0, 3, 3);   // H=9 again, column 2
        n_cmp++;
        if (best_score !== 8'd9 || best_col !== COL_W'(1) || h_prev !== 8'd9) begin
            n_err++;
            $display("FAIL best_tie: best=%0d col=%0d prev=%0d want best=9 col=1 prev=9",
                     best_score, best_col, h_prev);
        end
    endtask

    task automatic test_reset_start();
        drive(1, 0, 20, 0, 0, 0, 0, 1, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({out_valid, h_out, h_prev, best_score, best_col} !== '0 || out_pos !== POS_W'(NO_POS)) begin
            n_err++;
            $display("FAIL async_reset: valid=%0b h=%0d prev=%0d best=%0d col=%0d pos=%0d want zeros pos=%0d",
                     out_valid, h_out, h_prev, best_score, best_col, out_pos, NO_POS);
        end
        in_valid = 1'b1; h_diag = 8'd50;
        @(posedge clk);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        drive(1, 1, 2, 0, 0, 0, 0, 4, 4);   // H=4 as column 0
        n_cmp++;
        if (best_score !== 8'd4 || best_col !== COL_W'(0) || h_out !== 8'd4) begin
            n_err++;
            $display("FAIL start_valid: best=%0d col=%0d h=%0d want best=4 col=0 h=4",
                     best_score, best_col, h_out);
        end
        drive(1, 0, 3, 0, 0, 0, 0, 4, 4);   // H=5 must land in column 1
        n_cmp++;
        if (best_score !== 8'd5 || best_col !== COL_W'(1)) begin
            n_err++;
            $display("FAIL counter_after_start: best=%0d col=%0d want best=5 col=1",
                     best_score, best_col);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive((i % 7 == 6) ? 0 : 1, (i == 20) ? 1 : 0,
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            n_cmp++;
            if ({out_valid, h_out, h_prev, e_out, f_out, out_dir, out_pos, best_score, best_col} !==
                {got.valid[0], SCORE_W'(got.h), SCORE_W'(got.prev), SCORE_W'(got.e), SCORE_W'(got.f),
                 2'(got.dir), POS_W'(got.pos), SCORE_W'(got.best), COL_W'(got.bcol)}) begin
                n_err++;
                $display("FAIL b2b[%0d]: got v=%0b h=%0d p=%0d e=%0d f=%0d d=%0d pos=%0d b=%0d c=%0d want v=%0d h=%0d p=%0d e=%0d f=%0d d=%0d pos=%0d b=%0d c=%0d",
                         i, out_valid, h_out, h_prev, e_out, f_out, out_dir, out_pos, best_score, best_col,
                         got.valid, got.h, got.prev, got.e, got.f, got.dir, got.pos, got.best, got.bcol);
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_match_diag();
        test_saturation();
        test_zero_floor();
        test_gap_tie();
        test_best_stall();
        test_reset_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_unit_affine.md
Name: pe_unit_affine

Overview:
Parametrised next-generation Smith-Waterman processing element for the systolic alignment array. Computes one local-alignment cell per valid beat using affine gap scoring (Gotoh H/E/F recurrences) with programmable-at-elaboration scores and saturating arithmetic. Adds a valid handshake, a traceback direction code, origin-position propagation, and a per-PE running best score with column index. One instance sits in each array column, daisy-chained to its neighbours.

Parameters:
SCORE_W, 8, width of H/E/F scores (unsigned, non-negative)
BASE_W, 3, width of nucleotide code
POS_W, 3, width of origin-position tag; all-ones is the "no origin" sentinel
COL_W, 10, width of column counter and best_col
MATCH, 2, added on base match
MISMATCH, 1, subtracted on base mismatch
GAP_OPEN, 2, subtracted when opening a gap from H
GAP_EXT, 1, subtracted when extending a gap from E/F

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-low
start  in  1  synchronous clear of column counter and best tracking
in_valid  in  1  cell inputs valid this cycle
ref_base  in  BASE_W  reference base
qry_base  in  BASE_W  query base held by this PE
h_diag  in  SCORE_W  H of diagonal neighbour
h_up  in  SCORE_W  H of upper neighbour
h_left  in  SCORE_W  H of left neighbour
e_left  in  SCORE_W  E of left neighbour
f_up  in  SCORE_W  F of upper neighbour
pos_diag, pos_up, pos_left  in  POS_W  origin tags of the three sources
out_valid  out  1  outputs below updated this cycle
h_out  out  SCORE_W  cell H
h_prev  out  SCORE_W  previous h_out (diagonal feed for next PE)
e_out  out  SCORE_W  cell E
f_out  out  SCORE_W  cell F
out_pos  out  POS_W  origin tag of winning source
out_dir  out  2  traceback: 00 zero, 01 diag, 10 up, 11 left
best_score  out  SCORE_W  max h_out since last start
best_col  out  COL_W  column index of best_score

Behaviour:
- Only one clock. Reset is asynchronous and active-low: while low, every output register is 0 except out_pos = all-ones; column counter = 0.
- Arithmetic: signed, SCORE_W+2 bits internally. Every subtraction is floored at 0; every sum is clamped to 2^SCORE_W-1.
- s = MATCH when ref_base == qry_base, else -MISMATCH.
- E = max(h_left-GAP_OPEN, e_left-GAP_EXT); F = max(h_up-GAP_OPEN, f_up-GAP_EXT); D = h_diag + s.
- H = max(0, D, F, E).
- Tie priority is diag > up > left. If H is 0, dir = 00 and out_pos = all-ones, even when a source also equals 0.
- out_pos follows the winner: pos_diag, pos_up or pos_left.
- Latency 1 cycle. On the edge where in_valid=1:
  - h_prev <= h_out; h_out/e_out/f_out/out_dir/out_pos <= computed values; out_valid <= 1.
  - Column counter increments, wrapping modulo 2^COL_W.
- When in_valid=0: all data outputs and the counter hold; out_valid <= 0.
- Best tracking: when in_valid and H > best_score (strictly greater), best_score <= H and best_col <= current counter value. Ties keep the earliest column.
- start=1 clears the counter and best_score/best_col to 0; h_out/e_out/f_out/h_prev are unaffected.
- start and in_valid in the same cycle: the cell is processed as column 0 and best compares against 0. The counter becomes 1 and best updates only if H > 0.
- Reset asserted mid-stream aborts immediately; the first valid after release is column 0.

Test Plan:
- Match, diag wins: h_diag=5, h_up=6, f_up=3, h_left=4, e_left=0, bases equal, in_valid=1 -> next cycle h_out=7, f_out=4, e_out=2, out_dir=01, out_pos=pos_diag, out_valid=1.
- Saturation: h_diag=254, bases equal -> h_out=255, out_dir=01. Then h_diag=255 with mismatch -> h_out=254.
- Zero floor: all H/E/F inputs 0, bases differ -> h_out=0, e_out=0, f_out=0, out_dir=00, out_pos=7.
- Gap extension tie: h_diag=0 mismatch, h_up=10, f_up=9, h_left=0 -> f_out=8 (open and extend both give 8), h_out=8, out_dir=10, out_pos=pos_up.
- Best tracking with stall: start, then valid cells giving H=3,9,9 with an in_valid=0 gap between the 2nd and 3rd -> best_score=9, best_col=1, out_valid low during the gap, h_prev=9 after the 3rd cell.
- Reset/start interaction: release reset mid-stream, then start+in_valid with H=4 -> best_score=4, best_col=0, counter=1. Assert reset asynchronously between edges -> outputs 0 and out_pos=7 before the next edge.
